conv3x3_stream_filter: RTL



---
 rtl/conv3x3_stream_filter.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/conv3x3_stream_filter.sv
// Streaming 3x3 convolution over a raster RGB pixel stream: two line buffers feed
// a sliding window, a per-channel run-time kernel with saturation, 2-cycle output pipe.
module conv3x3_stream_filter #(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int CH_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 in_sop,
    input  logic [3*CH_BITS-1:0] data_in,
    input  logic [1:0]           mode,
    output logic                 out_valid,
    output logic                 out_sop,
    output logic                 out_eop,
    output logic [3*CH_BITS-1:0] out
);
    localparam int PIX_W = 3 * CH_BITS;
    localparam int ACC_W = CH_BITS + 5;
    localparam int SUM_W = CH_BITS + 2;
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((1 << CH_BITS) - 1);

    typedef enum logic {ST_WAIT_SOP, ST_ACTIVE} state_e;
    typedef enum logic [1:0] {
        K_IDENT = 2'd0,
        K_SHARP = 2'd1,
        K_GAUSS = 2'd2,
        K_RIDGE = 2'd3
    } kernel_e;

    function automatic logic [CH_BITS-1:0] chan(input logic [PIX_W-1:0] p, input int unsigned ch);
        return p[ch*CH_BITS +: CH_BITS];
    endfunction

    state_e           r_state;
    kernel_e          r_mode;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;

    logic             w_accept;
    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    logic             w_last_col;
    logic             w_last_pix;
    logic             w_win_done;

    // An accepted in_sop pixel is always (0,0), regardless of the running counters.
    assign w_accept   = in_valid && (in_sop || (r_state == ST_ACTIVE));
    assign w_col      = in_sop ? '0 : r_col;
    assign w_row      = in_sop ? '0 : r_row;
    assign w_last_col = (w_col == COL_W'(IMG_W - 1));
    assign w_last_pix = w_last_col && (w_row == ROW_W'(IMG_H - 1));
    assign w_win_done = w_accept && (w_row >= ROW_W'(2)) && (w_col >= COL_W'(2));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_WAIT_SOP;
            r_mode  <= K_IDENT;
            r_col   <= '0;
            r_row   <= '0;
        end else if (w_accept) begin
            if (in_sop) begin
                r_mode <= kernel_e'(mode);
            end
            if (w_last_pix) begin
                r_state <= ST_WAIT_SOP;
                r_col   <= '0;
                r_row   <= '0;
            end else begin
                r_state <= ST_ACTIVE;
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= w_row + ROW_W'(1);
                end else begin
                    r_col <= w_col + COL_W'(1);
                    r_row <= w_row;
                end
            end
        end
    end

    logic [PIX_W-1:0] r_lb1 [IMG_W];
    logic [PIX_W-1:0] r_lb2 [IMG_W];
    logic [PIX_W-1:0] w_lb1_rd;
    logic [PIX_W-1:0] w_lb2_rd;
    logic [PIX_W-1:0] r_win [3][3];

    assign w_lb1_rd = r_lb1[w_col];
    assign w_lb2_rd = r_lb2[w_col];

    // Line buffer 1 holds row r-1, line buffer 2 row r-2; window column 2 is newest.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb1[w_col] <= data_in;
            r_lb2[w_col] <= w_lb1_rd;
            for (int unsigned i = 0; i < 3; i++) begin
                r_win[i][0] <= r_win[i][1];
                r_win[i][1] <= r_win[i][2];
            end
            r_win[0][2] <= w_lb2_rd;
            r_win[1][2] <= w_lb1_rd;
            r_win[2][2] <= data_in;
        end
    end

    logic    r_v0;
    logic    r_v0_sop;
    logic    r_v0_eop;
    kernel_e r_v0_mode;
    logic    r_v1;
    logic    r_v1_sop;
    logic    r_v1_eop;
    kernel_e r_v1_mode;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v0      <= 1'b0;
            r_v0_sop  <= 1'b0;
            r_v0_eop  <= 1'b0;
            r_v0_mode <= K_IDENT;
            r_v1      <= 1'b0;
            r_v1_sop  <= 1'b0;
            r_v1_eop  <= 1'b0;
            r_v1_mode <= K_IDENT;
        end else begin
            r_v0      <= w_win_done;
            r_v0_sop  <= w_win_done && (w_row == ROW_W'(2)) && (w_col == COL_W'(2));
            r_v0_eop  <= w_win_done && w_last_pix;
            r_v0_mode <= r_mode;
            r_v1      <= r_v0;
            r_v1_sop  <= r_v0_sop;
            r_v1_eop  <= r_v0_eop;
            r_v1_mode <= r_v0_mode;
        end
    end

    logic [SUM_W-1:0]   w_edge   [3];
    logic [SUM_W-1:0]   w_corner [3];
    logic [CH_BITS-1:0] r_s1_c   [3];
    logic [SUM_W-1:0]   r_s1_e   [3];
    logic [SUM_W-1:0]   r_s1_k   [3];

    always_comb begin
        for (int unsigned ch = 0; ch < 3; ch++) begin
            w_edge[ch]   = '0;
            w_corner[ch] = '0;
        end
        for (int unsigned ch = 0; ch < 3; ch++) begin
            w_edge[ch]   = SUM_W'(chan(r_win[0][1], ch)) + SUM_W'(chan(r_win[2][1], ch))
                         + SUM_W'(chan(r_win[1][0], ch)) + SUM_W'(chan(r_win[1][2], ch));
            w_corner[ch] = SUM_W'(chan(r_win[0][0], ch)) + SUM_W'(chan(r_win[0][2], ch))
                         + SUM_W'(chan(r_win[2][0], ch)) + SUM_W'(chan(r_win[2][2], ch));
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned ch = 0; ch < 3; ch++) begin
            r_s1_c[ch] <= chan(r_win[1][1], ch);
            r_s1_e[ch] <= w_edge[ch];
            r_s1_k[ch] <= w_corner[ch];
        end
    end

    logic signed [ACC_W-1:0] w_ce  [3];
    logic signed [ACC_W-1:0] w_ee  [3];
    logic signed [ACC_W-1:0] w_ke  [3];
    logic signed [ACC_W-1:0] w_acc [3];
    logic [CH_BITS-1:0]      w_sat [3];
    logic [PIX_W-1:0]        w_out;

    always_comb begin
        w_out = '0;
        for (int unsigned ch = 0; ch < 3; ch++) begin
            w_ce[ch] = ACC_W'(r_s1_c[ch]);
            w_ee[ch] = ACC_W'(r_s1_e[ch]);
            w_ke[ch] = ACC_W'(r_s1_k[ch]);
            case (r_v1_mode)
                K_IDENT: w_acc[ch] = w_ce[ch];
                K_SHARP: w_acc[ch] = (w_ce[ch] <<< 2) + w_ce[ch] - w_ee[ch];
                K_GAUSS: w_acc[ch] = (w_ke[ch] + (w_ee[ch] <<< 1) + (w_ce[ch] <<< 2)) >>> 4;
                K_RIDGE: w_acc[ch] = (w_ce[ch] <<< 3) - w_ee[ch] - w_ke[ch];
                default: w_acc[ch] = w_ce[ch];
            endcase
            if (w_acc[ch][ACC_W-1]) begin
                w_sat[ch] = '0;
            end else if (w_acc[ch] > MAX_V) begin
                w_sat[ch] = '1;
            end else begin
                w_sat[ch] = w_acc[ch][CH_BITS-1:0];
            end
            w_out[ch*CH_BITS +: CH_BITS] = w_sat[ch];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out       <= '0;
        end else begin
            out_valid <= r_v1;
            out_sop   <= r_v1 && r_v1_sop;
            out_eop   <= r_v1 && r_v1_eop;
            if (r_v1) begin
                out <= w_out;
            end
        end
    end

endmodule
